mmio_timer: RTL
===============

# mmio_timer

Memory-mapped timer peripheral on the core's data bus, answering the same load/store strobes (`ena_rd`, `ena_wr`, byte address, 32-bit write data) that the core drives toward data RAM. It is the responder side of the core's data-memory interface: an address decoder upstream asserts `sel` for the timer window, and the timer returns read data with the same one-cycle registered latency as the synchronous RAM. It holds a prescaled 32-bit up-counter, a compare register, a sticky match flag and an interrupt output.

## Interface
- `PRESC_W`, 16, width of the prescaler divisor register (1..32).
- `AUTO_RELOAD_RST`, 0, reset value of CTRL.bit1.
- `CLOCK`  input  1  single system clock, all logic on rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `sel`  input  1  timer window selected by the address decoder; strobes are ignored when low.
- `ena_rd`  input  1  load strobe from core, one cycle per access.
- `ena_wr`  input  1  store strobe from core, one cycle per access.
- `addr`  input  5  byte offset within window; `addr[1:0]` ignored (word access only).
- `din`  input  32  store data.
- `dout`  output  32  registered load data.
- `irq`  output  1  level interrupt, `STATUS.match & CTRL.irq_en`.

## Operation
- Register map (word offsets): 0x00 CTRL {bit0 `en`, bit1 `auto_reload`, bit2 `irq_en`, others read 0}; 0x04 PRESC (`PRESC_W` bits, zero-extended on read); 0x08 COUNT (32 bits, read/write); 0x0C CMP (32 bits); 0x10 STATUS {bit0 `match`, write-1-to-clear}. Offsets 0x14-0x1C: read 0, writes ignored.
- Prescaler: internal counter `pcnt` (`PRESC_W` bits). While `en`=1: if `pcnt == PRESC` then `tick`=1 and `pcnt`<=0, else `pcnt`<=`pcnt`+1. PRESC=0 gives a tick every cycle; PRESC=N gives a tick every N+1 cycles. While `en`=0: `pcnt` held at 0, no ticks.
- On `tick`: if `COUNT == CMP` then `match`<=1 and COUNT<=(`auto_reload` ? 0 : COUNT+1); else COUNT<=COUNT+1. Addition is modulo 2^32 (0xFFFFFFFF wraps to 0, no flag).
- Writes (`sel & ena_wr`) take effect at the clock edge; registers not addressed are unaffected.
- Reads (`sel & ena_rd`): `dout`<= addressed register value as it was before that edge (read-before-write when both strobes are high at the same offset). With no read, `dout` holds its last value.
- `irq` is combinational from the registered `match` and `irq_en`; no other state.

## Timing
- Reset (RST=1 at an edge): CTRL=`{irq_en=0, auto_reload=AUTO_RELOAD_RST, en=0}`, PRESC=0, COUNT=0, CMP=0xFFFFFFFF, `match`=0, `pcnt`=0, `dout`=0, `irq`=0. Reset overrides any same-cycle access or tick; reset mid-count discards all progress.
- Load latency: strobe in cycle N, data valid on `dout` in cycle N+1, identical to data RAM.
- Store latency: new value readable by a load issued in cycle N+1.
- Write to COUNT in the same cycle as a `tick`: software value wins, tick's increment and compare are discarded for that cycle (`match` is not set by it).
- Write to PRESC: `pcnt`<=0 in the same edge; next tick occurs PRESC+1 cycles later.
- Write to CTRL clearing `en`: `pcnt`<=0 at that edge; a tick already due in that cycle (computed from old `en`=1) is still applied.
- STATUS write with bit0=1 in the same cycle a tick sets `match`: set wins, `match` stays 1.
- `sel`=0: strobes have no effect, `dout` holds.

## Test plan
- Reset: drive RST=1 two cycles, then read 0x00, 0x08, 0x0C, 0x10 -> `dout` = 0x0, 0x0, 0xFFFFFFFF, 0x0 one cycle after each strobe; `irq`=0.
- Free-run: PRESC=0, CMP=5, CTRL=0x5 (en, irq_en) -> COUNT increments each cycle; `match`=1 and `irq`=1 on the edge after the tick where COUNT==5; COUNT continues 6, 7, ...; write STATUS=0x1 -> `irq` falls next cycle.
- Prescaler and auto-reload: PRESC=3, CMP=2, CTRL=0x3 -> COUNT sequence 0,1,2,0,1,2 changing every 4 cycles; `match` set after first 2->0 transition.
- Wrap: COUNT=0xFFFFFFFE, CMP=0x10, PRESC=0, en=1 -> COUNT 0xFFFFFFFF then 0x00000000; `match` stays 0.
- Collisions: write COUNT=0x100 in a tick cycle -> COUNT reads 0x100; W1C STATUS in the cycle `match` is set -> `match` reads 1; read+write CMP same cycle -> `dout` shows old CMP.
- Decode: access with `sel`=0, offset 0x18, and `addr[1:0]`=2'b11 at 0x0C -> no state change / read 0 / behaves as word 0x0C.

Source files
------------

// File: rtl/mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
//
// Memory-mapped timer peripheral sitting on the core's data bus. It answers
// the same load/store strobes the core drives toward data RAM and returns
// load data with the same one-cycle registered latency as that RAM.
//
// Contents: a prescaled 32-bit up-counter, a compare register, a sticky match
// flag (write-1-to-clear) and a level interrupt output.
//
// Register map (word offsets inside the window):
//   0x00 CTRL   bit0 en, bit1 auto_reload, bit2 irq_en (other bits read 0)
//   0x04 PRESC  PRESC_W-bit prescaler divisor, zero-extended on read
//   0x08 COUNT  32-bit counter, read/write
//   0x0C CMP    32-bit compare value
//   0x10 STATUS bit0 match, write 1 to clear
//   0x14-0x1C   read 0, writes ignored
//
// Ports:
//   CLOCK   in   system clock, all logic on rising edge
//   RST     in   synchronous active-high reset
//   sel     in   timer window selected by the upstream address decoder
//   ena_rd  in   load strobe (one cycle per access)
//   ena_wr  in   store strobe (one cycle per access)
//   addr    in   [4:0] byte offset in window, addr[1:0] ignored
//   din     in   [31:0] store data
//   dout    out  [31:0] registered load data, held when no load occurs
//   irq     out  level interrupt = STATUS.match & CTRL.irq_en
// -----------------------------------------------------------------------------
module mmio_timer #(
  parameter int PRESC_W         = 16,
  parameter bit AUTO_RELOAD_RST = 1'b0
) (
  input  logic        CLOCK,
  input  logic        RST,
  input  logic        sel,
  input  logic        ena_rd,
  input  logic        ena_wr,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  // Word indices (addr[4:2]) of the implemented registers.
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PRESC  = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_CMP    = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic               r_en;
  logic               r_auto_reload;
  logic               r_irq_en;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_pcnt;
  logic [31:0]        r_count;
  logic [31:0]        r_cmp;
  logic               r_match;
  logic [31:0]        r_dout;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_word;
  logic        w_ctrl_wr;
  logic        w_presc_wr;
  logic        w_count_wr;
  logic        w_cmp_wr;
  logic        w_status_wr;

  always_comb begin
    w_wr        = sel & ena_wr;
    w_rd        = sel & ena_rd;
    w_word      = addr[4:2];
    w_ctrl_wr   = w_wr && (w_word == ADDR_CTRL);
    w_presc_wr  = w_wr && (w_word == ADDR_PRESC);
    w_count_wr  = w_wr && (w_word == ADDR_COUNT);
    w_cmp_wr    = w_wr && (w_word == ADDR_CMP);
    w_status_wr = w_wr && (w_word == ADDR_STATUS);
  end

  // Byte-lane bits are not decoded: every access is treated as a word access.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, addr[1:0]};

  // ---------------------------------------------------------------------------
  // Tick and compare
  // ---------------------------------------------------------------------------
  // The tick is derived purely from the state before the edge, so a store that
  // lands in the same cycle (e.g. clearing en or reloading PRESC) never
  // cancels a tick that was already due.
  logic        w_tick;
  logic        w_hit;
  logic [31:0] w_count_inc;

  always_comb begin
    w_tick      = r_en && (r_pcnt == r_presc);
    w_hit       = w_tick && (r_count == r_cmp);
    w_count_inc = r_count + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // CTRL
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_en          <= 1'b0;
      r_auto_reload <= AUTO_RELOAD_RST;
      r_irq_en      <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en          <= din[0];
      r_auto_reload <= din[1];
      r_irq_en      <= din[2];
    end
  end

  // ---------------------------------------------------------------------------
  // PRESC and prescaler counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_presc <= '0;
    end else if (w_presc_wr) begin
      r_presc <= din[PRESC_W-1:0];
    end
  end

  // pcnt restarts from 0 on a new divisor so the first tick after a PRESC
  // store lands exactly PRESC+1 cycles later. Disabling the timer also parks
  // it at 0; enabling from a parked state needs no special case.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_pcnt <= '0;
    end else if (w_presc_wr || (w_ctrl_wr && !din[0]) || !r_en || w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PCNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // COUNT
  // ---------------------------------------------------------------------------
  // A software store always wins over the tick in the same cycle; the wrap
  // from 0xFFFFFFFF to 0 is the natural 32-bit overflow and raises nothing.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_count <= '0;
    end else if (w_count_wr) begin
      r_count <= din;
    end else if (w_hit) begin
      r_count <= r_auto_reload ? 32'd0 : w_count_inc;
    end else if (w_tick) begin
      r_count <= w_count_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // CMP
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_cmp <= 32'hFFFF_FFFF;
    end else if (w_cmp_wr) begin
      r_cmp <= din;
    end
  end

  // ---------------------------------------------------------------------------
  // STATUS.match
  // ---------------------------------------------------------------------------
  // Set has priority over a simultaneous write-1-to-clear so an event is never
  // lost. A COUNT store in the tick cycle discards that tick's compare, so it
  // cannot set the flag.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_match <= 1'b0;
    end else if (w_hit && !w_count_wr) begin
      r_match <= 1'b1;
    end else if (w_status_wr && din[0]) begin
      r_match <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data
  // ---------------------------------------------------------------------------
  logic [31:0] w_presc_ext;
  logic [31:0] w_rdata;

  always_comb begin
    w_presc_ext                = '0;
    w_presc_ext[PRESC_W-1:0]   = r_presc;
  end

  // Selected from pre-edge state, which gives read-before-write ordering when
  // a load and a store hit the same offset in one cycle.
  always_comb begin
    w_rdata = '0;
    case (w_word)
      ADDR_CTRL:   w_rdata = {29'd0, r_irq_en, r_auto_reload, r_en};
      ADDR_PRESC:  w_rdata = w_presc_ext;
      ADDR_COUNT:  w_rdata = r_count;
      ADDR_CMP:    w_rdata = r_cmp;
      ADDR_STATUS: w_rdata = {31'd0, r_match};
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_dout <= '0;
    end else if (w_rd) begin
      r_dout <= w_rdata;
    end
  end

  assign dout = r_dout;
  assign irq  = r_match & r_irq_en;

endmodule
